io_port_controller: RTL and testbench
=====================================

# io_port_controller

Peripheral-side I/O block for the 16-bit five-stage RISC processor. It buffers words from an external input device into a small FIFO and presents the head word on the processor's `In` port. It captures words the processor writes to its `Out` port into a second FIFO and drains them to an external output device over a valid/ready handshake. It also generates the processor's `Int` request when input data arrives.

## Interface
Parameters:
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `WIDTH`, 16: data width; matches processor port width.

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `dev_in_data`  in  WIDTH  word from input device.
- `dev_in_valid`  in  1  input device offers `dev_in_data`.
- `dev_in_ready`  out  1  input FIFO not full; a word is accepted on an edge where valid && ready.
- `cpu_in`  out  WIDTH  to processor `In`; head of input FIFO, 0 when empty.
- `cpu_in_rd`  in  1  one-cycle strobe: IN instruction consumed `cpu_in`; pops the head.
- `cpu_out`  in  WIDTH  from processor `Out`.
- `cpu_out_wr`  in  1  one-cycle strobe: OUT instruction wrote `cpu_out`.
- `dev_out_data`  out  WIDTH  head of output FIFO, 0 when empty.
- `dev_out_valid`  out  1  output FIFO not empty.
- `dev_out_ready`  in  1  output device accepts; pop on valid && ready.
- `int_en`  in  1  interrupt enable.
- `Int`  out  1  to processor `Int`; one-cycle pulse.
- `in_count`  out  log2(DEPTH)+1  input FIFO occupancy.
- `ovf`  out  1  sticky output-overflow flag.
- `ovf_clr`  in  1  clears `ovf`.

## Operation
- Both FIFOs are circular buffers. Each has read and write pointers of log2(DEPTH)+1 bits, including a wrap bit.
  - full: pointer indices are equal and wrap bits differ.
  - empty: pointers are fully equal.
  - Pointers wrap from DEPTH-1 to 0 and toggle the wrap bit.
- `dev_in_ready` = !in_full, combinational from registered pointers.
- Input push: occurs when `dev_in_valid && dev_in_ready`.
- Input pop: occurs when `cpu_in_rd && !in_empty`. A `cpu_in_rd` while empty is ignored, with no pointer change.
- Input simultaneous push and pop:
  - Non-empty, non-full FIFO: both happen and the count is unchanged.
  - Full FIFO: the pop happens. No push is accepted, because ready was 0.
- Output push: `cpu_out_wr` pushes `cpu_out` if the FIFO is not full, or if a drain (valid && ready) occurs on the same edge.
  - Otherwise the word is dropped and `ovf` is set.
- `ovf` stays set until an edge with `ovf_clr`=1. If `ovf_clr` and a new overflow occur on the same edge, `ovf` stays 1.
- Output drain: pops on `dev_out_valid && dev_out_ready`.
- Interrupt generation:
  - `Int` is registered. It is 1 for exactly one cycle following an edge that pushed into an empty input FIFO while `int_en`=1.
  - A push into a non-empty FIFO raises no interrupt.
  - Pushes after the FIFO is drained to empty raise a new pulse.
  - `int_en` is sampled on the push edge.

## Timing
- Reset (`Rst`=0) takes effect asynchronously. It clears pointers, `Int`, and `ovf`, and discards FIFO contents (storage need not be cleared).
- Output values while in reset:
  - `dev_in_ready`=1
  - `cpu_in`=0
  - `dev_out_valid`=0
  - `dev_out_data`=0
  - `in_count`=0
  - `Int`=0
  - `ovf`=0
- Reset asserted mid-transfer discards all buffered words. No handshake completes on that edge.
- Input latency: a word accepted on edge N appears on `cpu_in` and in `in_count` after edge N. `Int` is high for the cycle between edges N and N+1.
- Output latency: `cpu_out_wr` on edge N makes `dev_out_valid`=1 after edge N.
- Throughput: one push and one pop per FIFO per cycle, sustained.
- FIFO ordering is strict FIFO. No word is duplicated or lost except output overflow drops.

## Test plan
- Reset then idle:
  - During reset → `dev_in_ready`=1, `Int`=0, `cpu_in`=0, `dev_out_valid`=0.
  - Hold `cpu_in_rd`=1 → no change; `in_count` stays 0.
- Push 0x1234 with `int_en`=1 → after the edge, `cpu_in`=0x1234, `in_count`=1, and `Int` is high for exactly one cycle.
  - Push 0x5678 next → no `Int`; `in_count`=2.
- Fill the input FIFO with 4 words (0xA000..0xA003) → `dev_in_ready`=0.
  - Then `cpu_in_rd` together with `dev_in_valid` → one pop, no push, `in_count`=3, `cpu_in`=0xA001.
  - Pop 8 times with refills → pointers wrap and order is preserved.
- `cpu_out_wr` 0xBEEF with `dev_out_ready`=0 → `dev_out_valid`=1, `dev_out_data`=0xBEEF.
  - Write 4 more words → the 5th is dropped and `ovf`=1.
  - `ovf_clr` → `ovf`=0.
  - Full FIFO with write and drain on the same edge → write accepted, no overflow.
- Assert `Rst` low mid-stream with both FIFOs partially full → outputs go to reset values immediately. After release, the FIFOs are empty and the first new push raises `Int`.

Source files
------------

// File: rtl/io_port_controller.sv
// Processor-side I/O block: input-device FIFO feeding the CPU In port, and a
// CPU Out FIFO drained to an output device, plus the input-arrival interrupt.

module io_port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The top bit is the wrap bit, so plain binary increment wraps the index
  // and toggles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Contents are discarded by resetting the pointers; storage keeps stale data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;
endmodule

module io_port_controller #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [WIDTH-1:0]         dev_in_data,
  input  logic                     dev_in_valid,
  output logic                     dev_in_ready,
  output logic [WIDTH-1:0]         cpu_in,
  input  logic                     cpu_in_rd,
  input  logic [WIDTH-1:0]         cpu_out,
  input  logic                     cpu_out_wr,
  output logic [WIDTH-1:0]         dev_out_data,
  output logic                     dev_out_valid,
  input  logic                     dev_out_ready,
  input  logic                     int_en,
  output logic                     Int,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic                     ovf,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] in_head;
  logic [WIDTH-1:0] out_head;
  logic [AW:0]      in_cnt;
  logic [AW:0]      out_cnt;
  logic             in_full;
  logic             in_empty;
  logic             out_full;
  logic             out_empty;
  logic             in_push;
  logic             in_pop;
  logic             out_push;
  logic             out_pop;
  logic             out_drop;

  // Full/empty come from registered pointers only, so reset clears them at once.
  assign in_full   = (in_cnt == CNT_FULL);
  assign in_empty  = (in_cnt == '0);
  assign out_full  = (out_cnt == CNT_FULL);
  assign out_empty = (out_cnt == '0);

  assign in_push  = dev_in_valid && !in_full;
  assign in_pop   = cpu_in_rd && !in_empty;
  assign out_pop  = !out_empty && dev_out_ready;
  // A drain on the same edge frees the slot the write lands in.
  assign out_push = cpu_out_wr && (!out_full || out_pop);
  assign out_drop = cpu_out_wr && out_full && !out_pop;

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
    .clk     (Clk),
    .rst_n   (Rst),
    .push    (in_push),
    .pop     (in_pop),
    .wr_data (dev_in_data),
    .rd_data (in_head),
    .count   (in_cnt)
  );

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
    .clk     (Clk),
    .rst_n   (Rst),
    .push    (out_push),
    .pop     (out_pop),
    .wr_data (cpu_out),
    .rd_data (out_head),
    .count   (out_cnt)
  );

  assign dev_in_ready  = !in_full;
  assign cpu_in        = in_empty ? '0 : in_head;
  assign in_count      = in_cnt;
  assign dev_out_valid = !out_empty;
  assign dev_out_data  = out_empty ? '0 : out_head;

  // Interrupt only on the empty-to-non-empty transition of the input FIFO.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Int <= 1'b0;
    end else begin
      Int <= in_push && in_empty && int_en;
    end
  end

  // A new drop wins over a clear on the same edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ovf <= 1'b0;
    end else if (out_drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: scoreboard queues for both FIFOs,
// immediate assertions at every comparison point.

module tb_io_port_controller;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [WIDTH-1:0] dev_in_data;
  logic             dev_in_valid;
  logic             dev_in_ready;
  logic [WIDTH-1:0] cpu_in;
  logic             cpu_in_rd;
  logic [WIDTH-1:0] cpu_out;
  logic             cpu_out_wr;
  logic [WIDTH-1:0] dev_out_data;
  logic             dev_out_valid;
  logic             dev_out_ready;
  logic             int_en;
  logic             Int;
  logic [2:0]       in_count;
  logic             ovf;
  logic             ovf_clr;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] in_q[$];
  logic [WIDTH-1:0] out_q[$];

  io_port_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready),
    .cpu_in        (cpu_in),
    .cpu_in_rd     (cpu_in_rd),
    .cpu_out       (cpu_out),
    .cpu_out_wr    (cpu_out_wr),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .int_en        (int_en),
    .Int           (Int),
    .in_count      (in_count),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_in_head(input string tag);
    if (in_q.size() == 0) chk({tag, "_model_empty"}, 32'(cpu_in), 32'h0);
    else chk(tag, 32'(cpu_in), 32'(in_q.pop_front()));
  endtask

  task automatic chk_out_head(input string tag);
    if (out_q.size() == 0) chk({tag, "_model_empty"}, 32'(dev_out_data), 32'h0);
    else chk(tag, 32'(dev_out_data), 32'(out_q.pop_front()));
  endtask

  initial begin
    Rst = 1'b0;
    dev_in_data = '0; dev_in_valid = 1'b0; cpu_in_rd = 1'b0;
    cpu_out = '0; cpu_out_wr = 1'b0; dev_out_ready = 1'b0;
    int_en = 1'b0; ovf_clr = 1'b0;

    #3;
    chk("rst_in_ready", 32'(dev_in_ready), 32'h1);
    chk("rst_int", 32'(Int), 32'h0);
    chk("rst_cpu_in", 32'(cpu_in), 32'h0);
    chk("rst_out_valid", 32'(dev_out_valid), 32'h0);
    chk("rst_out_data", 32'(dev_out_data), 32'h0);
    chk("rst_in_count", 32'(in_count), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    step();
    Rst = 1'b1;

    // Reads on an empty FIFO are ignored.
    cpu_in_rd = 1'b1;
    step(); step();
    chk("idle_rd_count", 32'(in_count), 32'h0);
    chk("idle_rd_cpu_in", 32'(cpu_in), 32'h0);
    cpu_in_rd = 1'b0;

    // First arrival raises Int for one cycle; the second does not.
    int_en = 1'b1;
    dev_in_valid = 1'b1; dev_in_data = 16'h1234; in_q.push_back(16'h1234);
    step();
    chk("push1_int", 32'(Int), 32'h1);
    chk("push1_count", 32'(in_count), 32'h1);
    chk("push1_cpu_in", 32'(cpu_in), 32'h1234);
    dev_in_data = 16'h5678; in_q.push_back(16'h5678);
    step();
    chk("push2_int", 32'(Int), 32'h0);
    chk("push2_count", 32'(in_count), 32'h2);
    dev_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk_in_head("pop_head");
      cpu_in_rd = 1'b1;
      step();
      cpu_in_rd = 1'b0;
    end
    chk("drain_count", 32'(in_count), 32'h0);

    // Fill to full.
    dev_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dev_in_data = 16'hA000 + 16'(i);
      in_q.push_back(dev_in_data);
      step();
      chk("fill_int", 32'(Int), (i == 0) ? 32'h1 : 32'h0);
    end
    chk("full_ready", 32'(dev_in_ready), 32'h0);
    chk("full_count", 32'(in_count), 32'h4);

    // Pop while full with valid held: pop only.
    dev_in_data = 16'hDEAD;
    chk_in_head("full_pop_head");
    cpu_in_rd = 1'b1;
    step();
    chk("full_pop_count", 32'(in_count), 32'h3);
    chk("full_pop_cpu_in", 32'(cpu_in), 32'hA001);

    // Eight simultaneous pop+push cycles wrap both pointers.
    for (int i = 0; i < 8; i++) begin
      chk_in_head("wrap_head");
      dev_in_data = 16'hC000 + 16'(i);
      in_q.push_back(dev_in_data);
      step();
      chk("wrap_count", 32'(in_count), 32'h3);
      chk("wrap_int", 32'(Int), 32'h0);
    end
    dev_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_in_head("wrap_drain_head");
      step();
    end
    cpu_in_rd = 1'b0;
    chk("wrap_drain_count", 32'(in_count), 32'h0);
    chk("wrap_drain_ready", 32'(dev_in_ready), 32'h1);

    // int_en is sampled on the push edge.
    int_en = 1'b0;
    dev_in_valid = 1'b1; dev_in_data = 16'h1111; in_q.push_back(16'h1111);
    step();
    dev_in_valid = 1'b0;
    chk("noen_int", 32'(Int), 32'h0);
    chk_in_head("noen_head");
    cpu_in_rd = 1'b1;
    step();
    cpu_in_rd = 1'b0;
    int_en = 1'b1;
    dev_in_valid = 1'b1; dev_in_data = 16'h2222; in_q.push_back(16'h2222);
    step();
    dev_in_valid = 1'b0;
    chk("repulse_int", 32'(Int), 32'h1);
    step();
    chk("repulse_int_low", 32'(Int), 32'h0);
    chk_in_head("repulse_head");
    cpu_in_rd = 1'b1;
    step();
    cpu_in_rd = 1'b0;

    // Output FIFO: fill, overflow, clear.
    dev_out_ready = 1'b0;
    cpu_out_wr = 1'b1; cpu_out = 16'hBEEF; out_q.push_back(16'hBEEF);
    step();
    chk("out1_valid", 32'(dev_out_valid), 32'h1);
    chk("out1_data", 32'(dev_out_data), 32'hBEEF);
    for (int i = 1; i <= 4; i++) begin
      cpu_out = 16'h0B00 + 16'(i);
      if (i < 4) out_q.push_back(cpu_out);
      step();
      chk("out_fill_ovf", 32'(ovf), (i == 4) ? 32'h1 : 32'h0);
    end
    cpu_out_wr = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'h0);

    // Full FIFO: write with drain on the same edge is accepted.
    dev_out_ready = 1'b1; cpu_out_wr = 1'b1; cpu_out = 16'h0C00;
    chk_out_head("wr_drain_head");
    out_q.push_back(16'h0C00);
    step();
    dev_out_ready = 1'b0;
    chk("wr_drain_ovf", 32'(ovf), 32'h0);
    chk("wr_drain_valid", 32'(dev_out_valid), 32'h1);

    // Overflow and clear on the same edge: overflow wins.
    cpu_out = 16'h0D00; ovf_clr = 1'b1;
    step();
    cpu_out_wr = 1'b0; ovf_clr = 1'b0;
    chk("ovf_vs_clr", 32'(ovf), 32'h1);

    dev_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_out_head("out_drain_head");
      step();
    end
    dev_out_ready = 1'b0;
    chk("out_drain_valid", 32'(dev_out_valid), 32'h0);
    chk("out_drain_data", 32'(dev_out_data), 32'h0);

    // Mid-stream reset with both FIFOs partly full.
    dev_in_valid = 1'b1; cpu_out_wr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dev_in_data = 16'h3300 + 16'(i);
      cpu_out = 16'h4400 + 16'(i);
      step();
    end
    chk("pre_rst_count", 32'(in_count), 32'h2);
    chk("pre_rst_out_data", 32'(dev_out_data), 32'h4400);
    #2 Rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(dev_in_ready), 32'h1);
    chk("mid_rst_cpu_in", 32'(cpu_in), 32'h0);
    chk("mid_rst_count", 32'(in_count), 32'h0);
    chk("mid_rst_out_valid", 32'(dev_out_valid), 32'h0);
    chk("mid_rst_out_data", 32'(dev_out_data), 32'h0);
    chk("mid_rst_ovf", 32'(ovf), 32'h0);
    dev_in_valid = 1'b0; cpu_out_wr = 1'b0;
    in_q.delete(); out_q.delete();
    #2 Rst = 1'b1;

    dev_in_valid = 1'b1; dev_in_data = 16'h7777; in_q.push_back(16'h7777);
    step();
    dev_in_valid = 1'b0;
    chk("post_rst_int", 32'(Int), 32'h1);
    chk("post_rst_count", 32'(in_count), 32'h1);
    chk_in_head("post_rst_head");
    chk("post_rst_out_valid", 32'(dev_out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
